// File: rtl/adder_pkg.sv
// Shared helpers for the pipelined adder: chunk sizing and configuration legality.
package adder_pkg;

  // Bits added per pipeline stage.
  function automatic int unsigned chunk_w(input int unsigned width, input int unsigned stages);
    return (stages == 0) ? 0 : width / stages;
  endfunction

  // A configuration is legal when the width splits evenly into 1..width stages.
  function automatic bit cfg_ok(input int unsigned width, input int unsigned stages);
    return (stages != 0) && (stages <= width) && ((width % stages) == 0);
  endfunction

endpackage

// File: rtl/add_chunk.sv
// Combinational W-bit ripple-carry adder built from full-add cells.
//   a, b   : W-bit operands
//   cin    : carry into bit 0
//   s      : W-bit sum
//   cout   : carry out of bit W-1
//   c_msb  : carry into bit W-1 (used for signed overflow detection)
module add_chunk #(
  parameter int unsigned W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] s,
  output logic         cout,
  output logic         c_msb
);

  logic [W:0] c;

  // Full-add cell per bit, carry rippling upward.
  always_comb begin
    c    = '0;
    s    = '0;
    c[0] = cin;
    for (int i = 0; i < int'(W); i++) begin
      s[i]     = a[i] ^ b[i] ^ c[i];
      c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
  end

  assign cout  = c[W];
  assign c_msb = c[W - 1];

endmodule

// File: rtl/adder_pipe.sv
// Pipelined ripple-carry adder: a WIDTH-bit add split into STAGES chunks, one chunk
// per register stage, carry passed stage to stage. Valid/ready on both sides with
// full backpressure; bubbles collapse.
// Optional feature macro: ADDER_PIPE_OVF_EN adds the signed-overflow output ovf.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid / in_ready : operand handshake (in_ready depends only on state and out_ready)
//   a, b, cin           : operands and carry-in
//   out_valid/out_ready : result handshake; q/cout/ovf held while stalled
//   q, cout             : (a+b+cin) mod 2^WIDTH and carry out
//   ovf                 : signed overflow (ADDER_PIPE_OVF_EN only)
module adder_pipe
  import adder_pkg::*;
#(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] q,
`ifdef ADDER_PIPE_OVF_EN
  output logic             cout,
  output logic             ovf
`else
  output logic             cout
`endif
);

  localparam int unsigned CHUNK = chunk_w(WIDTH, STAGES);

  if (!cfg_ok(WIDTH, STAGES)) begin : g_bad_cfg
    $fatal(1, "adder_pipe: WIDTH must be a multiple of STAGES, 1 <= STAGES <= WIDTH");
  end

  // Stage registers: operands are shifted down by CHUNK per stage so each stage
  // always adds the low CHUNK bits of what it receives.
  logic [STAGES-1:0]            v_r;
  logic [STAGES-1:0]            c_r;
  logic [STAGES-1:0][WIDTH-1:0] s_r;
  logic [STAGES-1:0][WIDTH-1:0] a_r;
  logic [STAGES-1:0][WIDTH-1:0] b_r;

  // Per-stage inputs and combinational results.
  logic [STAGES-1:0]            v_in;
  logic [STAGES-1:0]            c_in;
  logic [STAGES-1:0][WIDTH-1:0] a_in;
  logic [STAGES-1:0][WIDTH-1:0] b_in;
  logic [STAGES-1:0][WIDTH-1:0] s_in;
  logic [STAGES-1:0][WIDTH-1:0] s_nxt;
  logic [STAGES-1:0][CHUNK-1:0] sum_k;
  logic [STAGES-1:0]            c_out;
  logic [STAGES-1:0]            c_msb;
  logic [STAGES:0]              rdy;

  // Ready chain from the output backwards: a stage can load if empty or if its successor moves.
  always_comb begin
    rdy         = '0;
    rdy[STAGES] = out_ready;
    for (int k = int'(STAGES) - 1; k >= 0; k--) begin
      rdy[k] = !v_r[k] || rdy[k + 1];
    end
  end

  assign in_ready = rdy[0];

  for (genvar k = 0; k < int'(STAGES); k++) begin : g_stage
    if (k == 0) begin : g_first
      assign v_in[k] = in_valid;
      assign c_in[k] = cin;
      assign a_in[k] = a;
      assign b_in[k] = b;
      assign s_in[k] = '0;
    end else begin : g_next
      assign v_in[k] = v_r[k - 1];
      assign c_in[k] = c_r[k - 1];
      assign a_in[k] = a_r[k - 1];
      assign b_in[k] = b_r[k - 1];
      assign s_in[k] = s_r[k - 1];
    end

    add_chunk #(.W(CHUNK)) u_add (
      .a     (a_in[k][CHUNK-1:0]),
      .b     (b_in[k][CHUNK-1:0]),
      .cin   (c_in[k]),
      .s     (sum_k[k]),
      .cout  (c_out[k]),
      .c_msb (c_msb[k])
    );

    // Merge this chunk into the accumulated partial sum at its bit position.
    assign s_nxt[k] = s_in[k] | (WIDTH'(sum_k[k]) << (CHUNK * k));
  end

  // Stage registers; data only updates when a valid beat is loaded.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_r <= '0;
      c_r <= '0;
      s_r <= '0;
      a_r <= '0;
      b_r <= '0;
    end else begin
      for (int k = 0; k < int'(STAGES); k++) begin
        if (rdy[k]) begin
          v_r[k] <= v_in[k];
          if (v_in[k]) begin
            s_r[k] <= s_nxt[k];
            c_r[k] <= c_out[k];
            a_r[k] <= a_in[k] >> CHUNK;
            b_r[k] <= b_in[k] >> CHUNK;
          end
        end
      end
    end
  end

  assign out_valid = v_r[STAGES-1];
  assign q         = s_r[STAGES-1];
  assign cout      = c_r[STAGES-1];

`ifdef ADDER_PIPE_OVF_EN
  logic ovf_r;

  // Signed overflow: carry into MSB differs from carry out of MSB.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_r <= 1'b0;
    end else if (rdy[STAGES-1] && v_in[STAGES-1]) begin
      ovf_r <= c_msb[STAGES-1] ^ c_out[STAGES-1];
    end
  end

  assign ovf = ovf_r;
`endif

  // Last-stage operand remainders and intermediate MSB carries have no consumer.
  logic unused_bits;
  assign unused_bits = ^{a_r[STAGES-1], b_r[STAGES-1], c_msb};

endmodule

// File: tb/tb_adder_pipe.sv
// Self-checking bench for adder_pipe: directed cases, randomized streaming with
// random backpressure, stall/fill, mid-flight reset, optional overflow cases.
module tb_adder_pipe;

  localparam int unsigned WIDTH = 16;
  parameter int unsigned STAGES = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] q;
  logic             cout;
`ifdef ADDER_PIPE_OVF_EN
  logic             ovf;
`endif

  adder_pipe #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .q         (q),
`ifdef ADDER_PIPE_OVF_EN
    .cout      (cout),
    .ovf       (ovf)
`else
    .cout      (cout)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0] q;
    logic             c;
    logic             o;
    int               acc;
  } exp_t;

  exp_t             mq[$];
  int               n_tests = 0;
  int               n_fail  = 0;
  int               cyc     = 0;
  int               pops    = 0;
  logic             acc_now;
  logic             hold_pend;
  logic [WIDTH-1:0] hold_q;
  logic             hold_c;
  logic             lat_chk;
  logic [WIDTH-1:0] last_q;
  logic             last_c;
  logic             last_o;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Reference: plain integer arithmetic on the full values.
  function automatic exp_t model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                 input logic ci);
    exp_t            m;
    longint unsigned us;
    longint          ss;
    longint          smax;
    us   = longint'(x) + longint'(y) + longint'(ci);
    ss   = longint'($signed(x)) + longint'($signed(y)) + longint'(ci);
    smax = (longint'(1) << (WIDTH - 1)) - 1;
    m.q   = us[WIDTH-1:0];
    m.c   = us[WIDTH];
    m.o   = (ss > smax) || (ss < -(smax + 1));
    m.acc = 0;
    return m;
  endfunction

  // One clock cycle: drive at negedge, sample handshakes 1ns later, score transfers.
  task automatic step(input logic iv, input logic [WIDTH-1:0] ia, input logic [WIDTH-1:0] ib,
                      input logic ic, input logic ordy);
    exp_t e;
    @(negedge clk);
    in_valid  = iv;
    a         = ia;
    b         = ib;
    cin       = ic;
    out_ready = ordy;
    #1;
    cyc++;
    if (hold_pend) begin
      check("hold_valid", 32'(out_valid), 32'd1);
      check("hold_q", 32'(q), 32'(hold_q));
      check("hold_cout", 32'(cout), 32'(hold_c));
    end
    acc_now = in_valid && in_ready;
    if (acc_now) begin
      e     = model(ia, ib, ic);
      e.acc = cyc;
      mq.push_back(e);
    end
    if (out_valid && out_ready) begin
      check("out_expected", 32'(mq.size() > 0), 32'd1);
      if (mq.size() > 0) begin
        e = mq.pop_front();
        check("q", 32'(q), 32'(e.q));
        check("cout", 32'(cout), 32'(e.c));
`ifdef ADDER_PIPE_OVF_EN
        check("ovf", 32'(ovf), 32'(e.o));
        last_o = ovf;
`endif
        if (lat_chk) check("latency", 32'(cyc - e.acc), 32'(STAGES));
        pops++;
        last_q = q;
        last_c = cout;
      end
    end
    hold_pend = out_valid && !out_ready;
    hold_q    = q;
    hold_c    = cout;
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (mq.size() != 0 && n < budget) begin
      step(1'b0, '0, '0, 1'b0, 1'b1);
      n++;
    end
    check("drain_empty", 32'(mq.size()), 32'd0);
    step(1'b0, '0, '0, 1'b0, 1'b1);
    check("idle_valid", 32'(out_valid), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int               left;
    int               guard;
    int               acc;
    int               p0;
    int               want;
    logic [WIDTH-1:0] ra;
    logic [WIDTH-1:0] rb;
    logic             rc;

    in_valid  = 1'b0;
    a         = '0;
    b         = '0;
    cin       = 1'b0;
    out_ready = 1'b0;
    rst_n     = 1'b0;
    hold_pend = 1'b0;
    lat_chk   = 1'b0;
    last_q    = '0;
    last_c    = 1'b0;
    last_o    = 1'b0;

    // Reset state
    #3;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_q", 32'(q), 32'd0);
    check("rst_cout", 32'(cout), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
`ifdef ADDER_PIPE_OVF_EN
    check("rst_ovf", 32'(ovf), 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    // Simple add with latency check
    lat_chk = 1'b1;
    step(1'b1, 16'h0003, 16'h0004, 1'b0, 1'b1);
    check("t1_accept", 32'(acc_now), 32'd1);
    drain(40);
    check("t1_q", 32'(last_q), 32'h0007);
    check("t1_cout", 32'(last_c), 32'd0);

    // Carry through every stage
    step(1'b1, 16'hFFFF, 16'h0000, 1'b1, 1'b1);
    drain(40);
    check("t2_q", 32'(last_q), 32'h0000);
    check("t2_cout", 32'(last_c), 32'd1);
    lat_chk = 1'b0;

    // Random stream, in_valid held high, random backpressure
    p0    = pops;
    left  = 100;
    guard = 0;
    ra    = WIDTH'($urandom);
    rb    = WIDTH'($urandom);
    rc    = 1'($urandom);
    while (left > 0 && guard < 3000) begin
      step(1'b1, ra, rb, rc, 1'($urandom));
      guard++;
      if (acc_now) begin
        left--;
        ra = WIDTH'($urandom);
        rb = WIDTH'($urandom);
        rc = 1'($urandom);
      end
    end
    check("t3_all_sent", 32'(left), 32'd0);
    drain(400);
    check("t3_pop_count", 32'(pops - p0), 32'd100);

    // Fill under a stall, then release
    p0  = pops;
    acc = 0;
    for (int i = 0; i < int'(STAGES) + 10; i++) begin
      step(1'b1, ra, rb, rc, 1'b0);
      if (acc_now) begin
        acc++;
        ra = WIDTH'($urandom);
        rb = WIDTH'($urandom);
        rc = 1'($urandom);
      end
    end
    check("t4_accepted", 32'(acc), 32'(STAGES));
    check("t4_in_ready", 32'(in_ready), 32'd0);
    check("t4_out_valid", 32'(out_valid), 32'd1);
    drain(100);
    check("t4_pop_count", 32'(pops - p0), 32'(STAGES));

    // Reset with beats in flight
    want = (STAGES < 3) ? int'(STAGES) : 3;
    acc  = 0;
    for (int i = 0; i < 10 && acc < want; i++) begin
      step(1'b1, WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), 1'b0);
      if (acc_now) acc++;
    end
    for (int i = 0; i < int'(STAGES); i++) step(1'b0, '0, '0, 1'b0, 1'b0);
    check("t5_pre_valid", 32'(out_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    check("t5_rst_valid", 32'(out_valid), 32'd0);
    check("t5_rst_q", 32'(q), 32'd0);
    check("t5_rst_cout", 32'(cout), 32'd0);
    check("t5_rst_in_ready", 32'(in_ready), 32'd1);
    mq.delete();
    hold_pend = 1'b0;
    #1;
    rst_n = 1'b1;
    p0      = pops;
    lat_chk = 1'b1;
    step(1'b1, WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), 1'b1);
    drain(40);
    check("t5_pop_count", 32'(pops - p0), 32'd1);
    lat_chk = 1'b0;

`ifdef ADDER_PIPE_OVF_EN
    // Signed overflow cases
    step(1'b1, 16'h7FFF, 16'h0001, 1'b0, 1'b1);
    drain(40);
    check("t6a_q", 32'(last_q), 32'h8000);
    check("t6a_ovf", 32'(last_o), 32'd1);
    step(1'b1, 16'h8000, 16'hFFFF, 1'b0, 1'b1);
    drain(40);
    check("t6b_ovf", 32'(last_o), 32'd1);
    check("t6b_cout", 32'(last_c), 32'd1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
